// File: rtl/hcms_29xx_serial.sv
// Byte-to-serial driver for an HCMS-29xx dot-matrix display: shifts bytes MSB-first on DIN/CLK,
// frames with CE/RS, and sequences the display reset. Define HCMS_BLANK_CTRL_EN for BLANK_i.
module hcms_29xx_serial #(
  parameter int unsigned CLK_DIV     = 6,
  parameter int unsigned FRAME_BYTES = 20,
  parameter int unsigned RST_CYCLES  = 16
) (
  input  logic       CLK_i,
  input  logic       RSTN_i,
`ifdef HCMS_BLANK_CTRL_EN
  input  logic       BLANK_i,
`endif
  input  logic [7:0] DATA_i,
  input  logic       DATA_LOAD,
  input  logic       RS_i,
  output logic       READY_o,
  output logic       HCMS_DIN_o,
  output logic       HCMS_CLK_o,
  output logic       HCMS_RS_o,
  output logic       HCMS_CE_o,
  output logic       HCMS_BL_o,
  output logic       HCMS_RST_o
);

  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PorW    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned CntW    = $clog2(FRAME_BYTES + 1);
  localparam int unsigned DivLast = (CLK_DIV > 0) ? CLK_DIV - 1 : 0;
  localparam int unsigned PorLast = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    StPor,
    StIdle,
    StShift,
    StWait,
    StLatchLo,
    StLatchHi
  } state_e;

  state_e          state_q, state_d;
  logic [PorW-1:0] por_cnt_q, por_cnt_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            half_q, half_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]      sreg_q, sreg_d;
  logic            rs_q, rs_d;
  logic            clk_pin_q, clk_pin_d;
  logic            ce_pin_q, ce_pin_d;
  logic            rst_pin_q, rst_pin_d;
  logic            accept;
  logic            div_last;

  assign READY_o  = (state_q == StIdle) || (state_q == StWait);
  assign accept   = READY_o && DATA_LOAD;
  assign div_last = (div_cnt_q == DivW'(DivLast));

  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      state_q    <= StPor;
      por_cnt_q  <= '0;
      div_cnt_q  <= '0;
      half_q     <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sreg_q     <= '0;
      rs_q       <= 1'b0;
      clk_pin_q  <= 1'b0;
      ce_pin_q   <= 1'b1;
      rst_pin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      por_cnt_q  <= por_cnt_d;
      div_cnt_q  <= div_cnt_d;
      half_q     <= half_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sreg_q     <= sreg_d;
      rs_q       <= rs_d;
      clk_pin_q  <= clk_pin_d;
      ce_pin_q   <= ce_pin_d;
      rst_pin_q  <= rst_pin_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    por_cnt_d  = por_cnt_q;
    div_cnt_d  = div_cnt_q;
    half_d     = half_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sreg_d     = sreg_q;
    rs_d       = rs_q;
    case (state_q)
      StPor: begin
        if (por_cnt_q == PorW'(PorLast)) begin
          state_d = StIdle;
        end else begin
          por_cnt_d = por_cnt_q + PorW'(1);
        end
      end
      StIdle: begin
        if (accept) begin
          sreg_d     = DATA_i;
          rs_d       = RS_i;
          byte_cnt_d = CntW'(1);
          div_cnt_d  = '0;
          half_d     = 1'b0;
          bit_cnt_d  = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            // Shift only at the end of a high half so DIN is stable across the rising edge.
            half_d = 1'b0;
            sreg_d = {sreg_q[6:0], 1'b0};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if (rs_q || (byte_cnt_q == CntW'(FRAME_BYTES))) begin
                state_d = StLatchLo;
              end else begin
                state_d = StWait;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      StWait: begin
        if (accept) begin
          sreg_d     = DATA_i;
          byte_cnt_d = byte_cnt_q + CntW'(1);
          state_d    = StShift;
        end
      end
      StLatchLo: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = StLatchHi;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      StLatchHi: begin
        if (div_last) begin
          div_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      default: state_d = StPor;
    endcase
  end

  // Pin levels are decoded from the next state and registered, so the pins never glitch.
  always_comb begin
    clk_pin_d = (state_d == StShift) && half_d;
    ce_pin_d  = !((state_d == StShift) || (state_d == StWait) || (state_d == StLatchLo));
    rst_pin_d = (state_d != StPor);
  end

  assign HCMS_DIN_o = sreg_q[7];
  assign HCMS_CLK_o = clk_pin_q;
  assign HCMS_RS_o  = rs_q;
  assign HCMS_CE_o  = ce_pin_q;
  assign HCMS_RST_o = rst_pin_q;

`ifdef HCMS_BLANK_CTRL_EN
  logic bl_q, bl_d;

  always_comb begin
    bl_d = (state_q == StPor) ? 1'b1 : BLANK_i;
  end

  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      bl_q <= 1'b1;
    end else begin
      bl_q <= bl_d;
    end
  end

  assign HCMS_BL_o = bl_q;
`else
  assign HCMS_BL_o = 1'b0;
`endif

endmodule

// File: tb/tb_hcms_29xx_serial.sv
// Directed self-checking bench for hcms_29xx_serial with CLK_DIV=2, FRAME_BYTES=2, RST_CYCLES=4.
module tb_hcms_29xx_serial;

  localparam int unsigned ClkDiv     = 2;
  localparam int unsigned FrameBytes = 2;
  localparam int unsigned RstCycles  = 4;
`ifdef HCMS_BLANK_CTRL_EN
  localparam logic BlPor = 1'b1;
`else
  localparam logic BlPor = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       data_load = 1'b0;
  logic       rs_i = 1'b0;
  logic       ready_o, hcms_din, hcms_clk, hcms_rs, hcms_ce, hcms_bl, hcms_rst;
`ifdef HCMS_BLANK_CTRL_EN
  logic       blank_i = 1'b0;
`endif

  always #5 clk = ~clk;

  hcms_29xx_serial #(
    .CLK_DIV    (ClkDiv),
    .FRAME_BYTES(FrameBytes),
    .RST_CYCLES (RstCycles)
  ) u_dut (
    .CLK_i     (clk),
    .RSTN_i    (rstn),
`ifdef HCMS_BLANK_CTRL_EN
    .BLANK_i   (blank_i),
`endif
    .DATA_i    (data_i),
    .DATA_LOAD (data_load),
    .RS_i      (rs_i),
    .READY_o   (ready_o),
    .HCMS_DIN_o(hcms_din),
    .HCMS_CLK_o(hcms_clk),
    .HCMS_RS_o (hcms_rs),
    .HCMS_CE_o (hcms_ce),
    .HCMS_BL_o (hcms_bl),
    .HCMS_RST_o(hcms_rst)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Serial capture and timing results of the most recent trace.
  logic [31:0] cap;
  int nbits, hi_bad, din_bad, rs_bad, fall_t, ce_rise_t, ready_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {READY, DIN, CLK, RS, CE, BL, RST} while reset is asserted.
  task automatic check_reset_vals(input string tag);
    check(tag, {25'd0, ready_o, hcms_din, hcms_clk, hcms_rs, hcms_ce, hcms_bl, hcms_rst},
          {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BlPor, 1'b0});
  endtask

  // Called with reset just released at a sample point; {RST, READY, CE, CLK} per clock.
  task automatic por_check(input string tag);
    for (int i = 1; i <= int'(RstCycles); i++) begin
      step();
      check($sformatf("%s_por%0d", tag, i), {28'd0, hcms_rst, ready_o, hcms_ce, hcms_clk},
            {28'd0, (i == int'(RstCycles)), (i == int'(RstCycles)), 1'b1, 1'b0});
      if (i < int'(RstCycles)) check($sformatf("%s_bl_por%0d", tag, i), {31'd0, hcms_bl},
                                     {31'd0, BlPor});
    end
  endtask

  // Follows one byte from the cycle after its accept edge (t=0) until READY_o returns.
  task automatic trace(input logic exp_rs);
    logic p_clk, p_ce, din_hi;
    int   hi_len;
    p_clk     = hcms_clk;
    p_ce      = hcms_ce;
    din_hi    = 1'b0;
    hi_len    = 0;
    fall_t    = -1;
    ce_rise_t = -1;
    ready_t   = -1;
    for (int t = 1; t <= 200; t++) begin
      step();
      if (hcms_rs !== exp_rs) rs_bad++;
      if (hcms_clk && !p_clk) begin
        cap    = {cap[30:0], hcms_din};
        nbits++;
        din_hi = hcms_din;
        hi_len = 1;
      end else if (hcms_clk) begin
        hi_len++;
        if (hcms_din !== din_hi) din_bad++;
      end
      if (!hcms_clk && p_clk) begin
        if (hi_len != int'(ClkDiv)) hi_bad++;
        fall_t = t;
      end
      if (hcms_ce && !p_ce) ce_rise_t = t;
      p_clk = hcms_clk;
      p_ce  = hcms_ce;
      if (ready_o) begin
        ready_t = t;
        break;
      end
    end
  endtask

  task automatic clear_trace();
    cap = '0; nbits = 0; hi_bad = 0; din_bad = 0; rs_bad = 0;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic rs);
    data_i    = d;
    rs_i      = rs;
    data_load = 1'b1;
    step();
    data_load = 1'b0;
  endtask

  initial begin
    logic [15:0] exp16;
    int          n_acc;
    logic        p_clk, p_ce, done;

    // Reset and power-on display reset
    rstn = 1'b0;
    repeat (3) step();
    check_reset_vals("reset_vals");
    rstn = 1'b1;
    por_check("init");

`ifdef HCMS_BLANK_CTRL_EN
    blank_i = 1'b0; step(); check("bl_low", {31'd0, hcms_bl}, 32'd0);
    blank_i = 1'b1; step(); check("bl_high", {31'd0, hcms_bl}, 32'd1);
    blank_i = 1'b0; step(); check("bl_low2", {31'd0, hcms_bl}, 32'd0);
`else
    step();
    check("bl_const", {31'd0, hcms_bl}, 32'd0);
`endif

    // Control transaction 0x32
    clear_trace();
    load_byte(8'h32, 1'b1);
    check("ctl_start", {29'd0, hcms_rs, hcms_ce, ready_o}, {29'd0, 3'b100});
    trace(1'b1);
    check("ctl_bits", {24'd0, cap[7:0]}, 32'h32);
    check("ctl_nbits", nbits, 8);
    check("ctl_hi_width", hi_bad, 0);
    check("ctl_din_stable", din_bad, 0);
    check("ctl_rs_held", rs_bad, 0);
    check("ctl_clk_fall_t", fall_t, 32);
    check("ctl_ce_rise_t", ce_rise_t, 34);
    check("ctl_ready_t", ready_t, 36);

    // Dot frame 0x04, 0x64 with the second load during WAIT
    clear_trace();
    load_byte(8'h04, 1'b0);
    check("dot_start", {29'd0, hcms_rs, hcms_ce, ready_o}, {29'd0, 3'b000});
    trace(1'b0);
    check("dot_wait_t", ready_t, 32);
    check("dot_gap_ce", {30'd0, hcms_ce, hcms_clk}, 32'd0);
    check("dot_gap_no_ce_rise", ce_rise_t, -1);
    load_byte(8'h64, 1'b1);
    check("dot_b2_start", {30'd0, hcms_ce, ready_o}, 32'd0);
    trace(1'b0);
    check("dot_bits", {16'd0, cap[15:0]}, 32'h0464);
    check("dot_nbits", nbits, 16);
    check("dot_hi_width", hi_bad, 0);
    check("dot_rs_held", rs_bad, 0);
    check("dot_ce_rise_t", ce_rise_t, 34);
    check("dot_ready_t", ready_t, 36);

    // DATA_LOAD held high, data changing every clock, RS_i toggling
    clear_trace();
    exp16 = '0; n_acc = 0; done = 1'b0;
    p_clk = hcms_clk; p_ce = hcms_ce;
    data_load = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      data_i = 8'(8'h13 + t * 29);
      rs_i   = (t % 3 == 2);
      if (ready_o) begin
        exp16 = {exp16[7:0], data_i};
        n_acc++;
      end
      step();
      if (hcms_rs !== 1'b0) rs_bad++;
      if (hcms_clk && !p_clk) begin
        cap = {cap[30:0], hcms_din};
        nbits++;
      end
      if (hcms_ce && !p_ce) begin
        data_load = 1'b0;
        done      = 1'b1;
      end
      p_clk = hcms_clk;
      p_ce  = hcms_ce;
    end
    check("hold_frame_end", {31'd0, done}, 32'd1);
    ready_t = -1;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (ready_o) begin
        ready_t = t;
        break;
      end
    end
    check("hold_ready_after", ready_t, 2);
    check("hold_n_accepts", n_acc, int'(FrameBytes));
    check("hold_bits", {16'd0, cap[15:0]}, {16'd0, exp16});
    check("hold_nbits", nbits, 16);
    check("hold_rs_ignored", rs_bad, 0);

    // Reset asserted during bit 4 of a control byte
    load_byte(8'hFF, 1'b1);
    repeat (14) step();
    check("abort_pre", {28'd0, hcms_clk, hcms_din, hcms_ce, hcms_rs}, {28'd0, 4'b1101});
    rstn = 1'b0;
    #1;
    check_reset_vals("abort_vals");
    repeat (2) step();
    rstn = 1'b1;
    por_check("abort");

    // Fresh transaction after the repeated POR
    clear_trace();
    load_byte(8'hA5, 1'b1);
    trace(1'b1);
    check("post_bits", {24'd0, cap[7:0]}, 32'hA5);
    check("post_ready_t", ready_t, 36);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hcms_29xx_serial.md
Name: hcms_29xx_serial

Overview:
Byte-wide-to-serial driver for an HCMS-29xx LED dot-matrix display. Accepts bytes through a ready/load handshake and shifts them MSB-first onto the display's DIN/CLK pins. Manages chip enable (CE), register select (RS), blank (BL) and power-on display reset. It sits between the character/frame generator logic and the display's I/O pins.

Parameters:
CLK_DIV, 6, system clocks per serial half-period; serial clock = f(CLK_i)/(2*CLK_DIV), must be >=1.
FRAME_BYTES, 20, bytes per dot-register frame (4 chars x 5 columns x 8 bits = 160 bits).
RST_CYCLES, 16, system clocks HCMS_RST_o is held low after reset.

Ports:
CLK_i  in  1  system clock, rising edge.
RSTN_i  in  1  reset; asynchronous assert, active-low.
DATA_i  in  8  byte to transmit, MSB sent first.
DATA_LOAD  in  1  load request; a byte is accepted on any rising edge where DATA_LOAD=1 and READY_o=1.
RS_i  in  1  register select for a new transaction: 0 = dot register, 1 = control register.
READY_o  out  1  high when a byte can be accepted.
HCMS_DIN_o  out  1  serial data.
HCMS_CLK_o  out  1  serial clock; idles low; the display samples on the rising edge.
HCMS_RS_o  out  1  register select to the display.
HCMS_CE_o  out  1  chip enable, active-low; a rising edge latches the data.
HCMS_BL_o  out  1  blank, active-high.
HCMS_RST_o  out  1  display reset, active-low.

Behaviour:
- Reset values (RSTN_i=0): READY_o=0, HCMS_DIN_o=0, HCMS_CLK_o=0, HCMS_RS_o=0, HCMS_CE_o=1, HCMS_BL_o=0, HCMS_RST_o=0. All counters are 0 and the FSM is in POR.
- States: POR, IDLE, SHIFT, WAIT, LATCH_LO, LATCH_HI.
- POR: HCMS_RST_o=0 for RST_CYCLES clocks after reset release, then HCMS_RST_o=1 and go to IDLE.
- IDLE: READY_o=1, CE=1, CLK=0.
  - On accept: latch DATA_i into the shift register.
  - Latch RS_i into HCMS_RS_o; RS is held for the whole transaction.
  - Byte count = 1, CE=0 on the next cycle, go to SHIFT.
- SHIFT (per byte, 16*CLK_DIV clocks): 8 bits, each consisting of a low half (DIN=bit, CLK=0, CLK_DIV clocks) followed by a high half (CLK=1, CLK_DIV clocks). Order is bit7 to bit0. DIN changes only at the start of a low half. READY_o=0.
- After bit0's high half, CLK goes to 0:
  - Control transaction (RS=1): go to LATCH_LO.
  - Dot transaction with byte count = FRAME_BYTES: go to LATCH_LO.
  - Otherwise: go to WAIT.
- WAIT: CE stays 0, CLK=0, READY_o=1. On accept: load the byte, increment the count, go to SHIFT. RS_i is ignored here. No timeout.
- LATCH_LO: CE=0, CLK=0 for CLK_DIV clocks. LATCH_HI: CE=1 for CLK_DIV clocks, then go to IDLE with READY_o=1.
- READY_o is combinational from state and drops the cycle after an accept. If DATA_LOAD is held high, bytes are accepted back-to-back at every READY_o=1 edge.
- Reset asserted mid-transfer aborts immediately to the reset values. A partial frame is discarded and the display is reset again via POR.
- DATA_LOAD while READY_o=0 is ignored. No buffering.

Optional Feature:
Macro HCMS_BLANK_CTRL_EN.
- Defined: adds input BLANK_i (1 bit). HCMS_BL_o is registered from BLANK_i, is forced to 1 during POR, and resets to 1.
- Undefined: no BLANK_i port; HCMS_BL_o is constant 0.

Test Plan:
Use CLK_DIV=2, FRAME_BYTES=2, RST_CYCLES=4 throughout.
- Reset release -> HCMS_RST_o low exactly 4 clocks, then high; READY_o rises in the same cycle; CE=1, CLK=0 throughout.
- RS_i=1, DATA_i=8'h32, single DATA_LOAD pulse:
  - HCMS_RS_o=1, CE falls the next cycle.
  - DIN sampled on the 8 CLK rising edges = 0,0,1,1,0,0,1,0.
  - Each CLK high lasts 2 clocks.
  - CE rises 2 clocks after the last CLK fall; READY_o returns 2 clocks later.
  - Total accept-to-READY = 36 clocks.
- RS_i=0, bytes 8'h04 then 8'h64 (2nd load during WAIT):
  - CE stays low between bytes; READY_o=1 in the gap.
  - 16 bits captured = 0x0464.
  - CE rises only after the second byte.
- DATA_LOAD held high with data changing every clock in a dot frame -> exactly FRAME_BYTES bytes accepted, each equal to DATA_i at its accept edge; RS_i toggled mid-frame has no effect on HCMS_RS_o.
- RSTN_i asserted during bit 4 of a byte -> outputs take reset values asynchronously (CE=1, RST_o=0); after release the full POR sequence repeats.
- With HCMS_BLANK_CTRL_EN: BLANK_i=1 -> HCMS_BL_o=1 one clock later; BLANK_i=0 -> HCMS_BL_o=0; HCMS_BL_o=1 throughout POR.
